// File: rtl/tile_scheduler.sv
// rtl/tile_scheduler.sv - walks one frame tile by tile: rasterize, hand off to the tile writer, then drain.
`timescale 1ns/1ps
module tile_scheduler #(
  parameter int TILE_BYTES     = 64,
  parameter int TILE_ROWS_LOG2 = 5,
  parameter int TX_BITS        = 6,
  parameter int TY_BITS        = 6
) (
  input  logic               gpu_clk,
  input  logic               gpu_rst_n,
  input  logic               frame_start,
  input  logic [31:0]        fb_addr_in,
  input  logic [15:0]        stride_in,
  input  logic [TX_BITS-1:0] tiles_x_in,
  input  logic [TY_BITS-1:0] tiles_y_in,
  output logic               busy,
  output logic               frame_done,
  output logic               render_start,
  output logic [TX_BITS-1:0] tile_x,
  output logic [TY_BITS-1:0] tile_y,
  input  logic               render_done,
  output logic               wr_start,
  output logic [31:0]        wr_addr,
  output logic [15:0]        wr_stride,
  input  logic               wr_reading,
  input  logic               wr_flushed
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RENDER,
    S_RWAIT,
    S_WSTART,
    S_WARM,
    S_WWAIT,
    S_DRAIN
  } state_t;

  localparam logic [TX_BITS-1:0] ONE_X     = TX_BITS'(1);
  localparam logic [TY_BITS-1:0] ONE_Y     = TY_BITS'(1);
  localparam logic [31:0]        TILE_STEP = 32'(TILE_BYTES);

  state_t             state;
  logic [TX_BITS-1:0] tiles_x;
  logic [TY_BITS-1:0] tiles_y;
  logic [31:0]        row_base;
  logic [31:0]        tile_addr;
  logic [31:0]        row_step;
  logic [31:0]        row_next;
  logic               last_x;
  logic               last_y;

  // One tile row down in the framebuffer is stride * tile height; the shift keeps it adder-only.
  assign row_step = {{(32 - 16 - TILE_ROWS_LOG2){1'b0}}, wr_stride, {TILE_ROWS_LOG2{1'b0}}};
  assign row_next = row_base + row_step;
  assign last_x   = (tile_x == tiles_x - ONE_X);
  assign last_y   = (tile_y == tiles_y - ONE_Y);

  // Frame sequencer: all handshake pulses and address registers are updated here.
  always_ff @(posedge gpu_clk or negedge gpu_rst_n) begin
    if (!gpu_rst_n) begin
      state        <= S_IDLE;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
      render_start <= 1'b0;
      wr_start     <= 1'b0;
      tile_x       <= '0;
      tile_y       <= '0;
      tiles_x      <= '0;
      tiles_y      <= '0;
      wr_addr      <= '0;
      wr_stride    <= '0;
      row_base     <= '0;
      tile_addr    <= '0;
    end else begin
      render_start <= 1'b0;
      wr_start     <= 1'b0;
      frame_done   <= 1'b0;
      case (state)
        S_IDLE: begin
          // The frame_done cycle is already idle, but a start there belongs to the old frame.
          if (frame_start && !frame_done) begin
            wr_stride <= stride_in;
            tiles_x   <= tiles_x_in;
            tiles_y   <= tiles_y_in;
            row_base  <= fb_addr_in;
            tile_addr <= fb_addr_in;
            tile_x    <= '0;
            tile_y    <= '0;
            busy      <= 1'b1;
            if (tiles_x_in == '0 || tiles_y_in == '0) begin
              state <= S_DRAIN;
            end else begin
              state        <= S_RENDER;
              render_start <= 1'b1;
            end
          end
        end
        S_RENDER: state <= S_RWAIT;
        S_RWAIT: begin
          if (render_done) begin
            state    <= S_WSTART;
            wr_start <= 1'b1;
            wr_addr  <= tile_addr;
          end
        end
        S_WSTART: state <= S_WARM;
        // The writer raises wr_reading one edge after wr_start, so it is not trusted yet.
        S_WARM:   state <= S_WWAIT;
        S_WWAIT: begin
          if (!wr_reading) begin
            if (last_x && last_y) begin
              state <= S_DRAIN;
            end else begin
              state        <= S_RENDER;
              render_start <= 1'b1;
              if (last_x) begin
                tile_x    <= '0;
                tile_y    <= tile_y + ONE_Y;
                row_base  <= row_next;
                tile_addr <= row_next;
              end else begin
                tile_x    <= tile_x + ONE_X;
                tile_addr <= tile_addr + TILE_STEP;
              end
            end
          end
        end
        S_DRAIN: begin
          if (wr_flushed) begin
            frame_done <= 1'b1;
            busy       <= 1'b0;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tile_scheduler.sv
// tb/tb_tile_scheduler.sv - randomized self-checking bench with rasterizer/writer models and an address scoreboard.
`timescale 1ns/1ps
module tb_tile_scheduler;

  logic        gpu_clk = 1'b0;
  logic        gpu_rst_n = 1'b0;
  logic        frame_start = 1'b0;
  logic [31:0] fb_addr_in = '0;
  logic [15:0] stride_in = '0;
  logic [5:0]  tiles_x_in = '0;
  logic [5:0]  tiles_y_in = '0;
  logic        busy, frame_done, render_start, wr_start;
  logic [5:0]  tile_x, tile_y;
  logic [31:0] wr_addr;
  logic [15:0] wr_stride;
  logic        render_done = 1'b0;
  logic        wr_reading = 1'b0;
  logic        wr_flushed = 1'b1;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Peripheral model knobs (written by the stimulus process only).
  int r_delay = 3;
  int w_len = 512;
  int f_delay = 20;
  bit flush_gate = 1'b1;
  bit spur_en = 1'b0;

  // Peripheral model state (written by the model process only).
  int rd_cnt = 0, rcnt = 0, fcnt = 0;
  bit pend = 1'b0, flushed_int = 1'b1, spur_done = 1'b0;
  int last_rd = -1, last_fall = -1;
  int rs_cnt = 0, ws_cnt = 0, fd_cnt = 0, fd_cyc = -1;

  // Scoreboard: filled at frame start, consumed on each wr_start.
  logic [31:0] exp_addr[$];
  logic [11:0] exp_tile[$];
  logic [15:0] exp_stride = '0;
  int rs_base = 0, ws_base = 0, fd_base = 0, start_cyc = 0;

  tile_scheduler dut (
    .gpu_clk(gpu_clk), .gpu_rst_n(gpu_rst_n), .frame_start(frame_start),
    .fb_addr_in(fb_addr_in), .stride_in(stride_in), .tiles_x_in(tiles_x_in),
    .tiles_y_in(tiles_y_in), .busy(busy), .frame_done(frame_done),
    .render_start(render_start), .tile_x(tile_x), .tile_y(tile_y),
    .render_done(render_done), .wr_start(wr_start), .wr_addr(wr_addr),
    .wr_stride(wr_stride), .wr_reading(wr_reading), .wr_flushed(wr_flushed)
  );

  initial forever #5 gpu_clk = ~gpu_clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Rasterizer, tile writer and event monitor, evaluated at every falling edge.
  initial forever begin
    @(negedge gpu_clk);
    cyc++;
    render_done = 1'b0;
    if (!gpu_rst_n) begin
      rd_cnt = 0; rcnt = 0; fcnt = 0; pend = 1'b0;
      wr_reading = 1'b0; flushed_int = 1'b1;
    end else begin
      if (!busy) begin
        last_fall = -1;
        spur_done = 1'b0;
      end
      if (render_start) begin
        rs_cnt++;
        chk("no_render_while_reading", 32'(wr_reading), 32'd0);
        if (last_fall >= 0) chk("render_after_fall", 32'(cyc - last_fall), 32'd1);
        rd_cnt = r_delay;
      end else if (rd_cnt > 0) begin
        rd_cnt--;
        if (rd_cnt == 0) begin
          render_done = 1'b1;
          last_rd = cyc;
        end
      end
      if (wr_start) begin
        ws_cnt++;
        chk("wr_start_after_done", 32'(cyc - last_rd), 32'd1);
        chk("wr_stride", 32'(wr_stride), 32'(exp_stride));
        if (exp_addr.size() == 0) begin
          chk("extra_wr_start", 32'd1, 32'd0);
        end else begin
          chk("wr_addr", wr_addr, exp_addr.pop_front());
          chk("tile_xy", 32'({tile_y, tile_x}), 32'(exp_tile.pop_front()));
        end
        pend = 1'b1;
        flushed_int = 1'b0;
        fcnt = 0;
      end else if (pend) begin
        pend = 1'b0;
        wr_reading = 1'b1;
        rcnt = w_len;
      end else if (wr_reading) begin
        rcnt--;
        if (spur_en && !spur_done && rcnt == 3) begin
          render_done = 1'b1;
          spur_done = 1'b1;
        end
        if (rcnt == 0) begin
          wr_reading = 1'b0;
          last_fall = cyc;
          fcnt = f_delay + 1;
        end
      end else if (fcnt > 0) begin
        fcnt--;
        if (fcnt == 0) flushed_int = 1'b1;
      end
      if (frame_done) begin
        fd_cnt++;
        fd_cyc = cyc;
        chk("busy_low_with_done", 32'(busy), 32'd0);
      end
    end
    wr_flushed = flush_gate && flushed_int;
  end

  task automatic step(int n);
    repeat (n) begin
      @(negedge gpu_clk);
      #1;
    end
  endtask

  // Expected tiles come straight from raster order: base + row*stride*height + col*tile width.
  task automatic start_frame(logic [31:0] base, logic [15:0] st, int tx, int ty);
    exp_addr.delete();
    exp_tile.delete();
    for (int y = 0; y < ty; y++) begin
      for (int x = 0; x < tx; x++) begin
        exp_addr.push_back(base + 32'(y) * (32'(st) * 32'd32) + 32'(x) * 32'd64);
        exp_tile.push_back({6'(y), 6'(x)});
      end
    end
    exp_stride = st;
    rs_base = rs_cnt;
    ws_base = ws_cnt;
    fd_base = fd_cnt;
    fb_addr_in = base;
    stride_in = st;
    tiles_x_in = 6'(tx);
    tiles_y_in = 6'(ty);
    frame_start = 1'b1;
    start_cyc = cyc;
    step(1);
    frame_start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
  endtask

  task automatic wait_done(string tag, int n_tiles, int budget);
    int n = 0;
    while (fd_cnt == fd_base && n < budget) begin
      step(1);
      n++;
    end
    chk({tag, "_done_seen"}, 32'(fd_cnt - fd_base), 32'd1);
    step(3);
    chk({tag, "_done_once"}, 32'(fd_cnt - fd_base), 32'd1);
    chk({tag, "_busy_low"}, 32'(busy), 32'd0);
    chk({tag, "_render_cnt"}, 32'(rs_cnt - rs_base), 32'(n_tiles));
    chk({tag, "_wr_cnt"}, 32'(ws_cnt - ws_base), 32'(n_tiles));
    chk({tag, "_left"}, 32'(exp_addr.size()), 32'd0);
  endtask

  initial begin
    int n;
    int tx, ty;
    // Reset state.
    step(2);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_pulses", 32'({frame_done, render_start, wr_start}), 32'd0);
    chk("rst_tile", 32'({tile_y, tile_x}), 32'd0);
    chk("rst_wr_addr", wr_addr, 32'd0);
    chk("rst_wr_stride", 32'(wr_stride), 32'd0);
    gpu_rst_n = 1'b1;
    step(2);
    chk("idle_busy", 32'(busy), 32'd0);

    // Reference frame: 2x2 tiles, long writer reads.
    r_delay = 3; w_len = 512; f_delay = 20;
    start_frame(32'h1000_0000, 16'h0A00, 2, 2);
    wait_done("frame2x2", 4, 5000);

    // Zero columns: drain only, frame_done waits for the flush.
    flush_gate = 1'b0;
    start_frame(32'h2000_0000, 16'h0100, 0, 3);
    step(10);
    chk("zero_wait_flush", 32'(fd_cnt - fd_base), 32'd0);
    chk("zero_busy", 32'(busy), 32'd1);
    flush_gate = 1'b1;
    wait_done("zero_x", 0, 50);

    // Zero rows with flush already high; a start in the frame_done cycle is ignored.
    start_frame(32'h3000_0000, 16'h0100, 3, 0);
    step(1);
    chk("zero_done_latency", 32'(fd_cyc - start_cyc), 32'd2);
    tiles_x_in = 6'd1;
    tiles_y_in = 6'd1;
    frame_start = 1'b1;
    step(1);
    frame_start = 1'b0;
    step(3);
    chk("start_in_done_cycle_busy", 32'(busy), 32'd0);
    chk("start_in_done_cycle_render", 32'(rs_cnt - rs_base), 32'd0);

    // Restart while busy and a stray render_done during the writer wait.
    r_delay = 2; w_len = 10; f_delay = 3; spur_en = 1'b1;
    start_frame(32'h4000_1000, 16'h0200, 3, 2);
    step(20);
    fb_addr_in = 32'h5555_0000;
    stride_in = 16'h0040;
    tiles_x_in = 6'd1;
    tiles_y_in = 6'd1;
    frame_start = 1'b1;
    step(1);
    frame_start = 1'b0;
    wait_done("busy_restart", 6, 1000);
    spur_en = 1'b0;

    // Reset while tile 1 is being rasterized.
    r_delay = 8; w_len = 12; f_delay = 2;
    start_frame(32'h6000_0000, 16'h0300, 3, 2);
    n = 0;
    while (rs_cnt - rs_base < 2 && n < 1000) begin
      step(1);
      n++;
    end
    chk("reach_tile1", 32'(rs_cnt - rs_base), 32'd2);
    step(2);
    chk("tile1_x", 32'(tile_x), 32'd1);
    gpu_rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_tile", 32'({tile_y, tile_x}), 32'd0);
    chk("midrst_addr", wr_addr, 32'd0);
    chk("midrst_stride", 32'(wr_stride), 32'd0);
    step(2);
    gpu_rst_n = 1'b1;
    step(3);
    chk("midrst_no_done", 32'(fd_cnt - fd_base), 32'd0);
    start_frame(32'h7000_0080, 16'h0110, 2, 2);
    wait_done("after_reset", 4, 1000);

    // Address wrap past 2^32.
    start_frame(32'hFFFF_FFC0, 16'h0100, 2, 1);
    wait_done("wrap", 2, 1000);

    // Randomized frames.
    for (int i = 0; i < 8; i++) begin
      r_delay = int'($urandom_range(1, 5));
      w_len = int'($urandom_range(6, 20));
      f_delay = int'($urandom_range(0, 8));
      tx = int'($urandom_range(1, 3));
      ty = int'($urandom_range(1, 3));
      start_frame($urandom, 16'($urandom), tx, ty);
      wait_done("rand", tx * ty, 2000);
      step(int'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
